// File: rtl/ms_latch_sequencer.sv
// rtl/ms_latch_sequencer.sv - round-robin writer for a master-slave latch bank with non-overlapping enables
// Define MS_SEQ_VERIFY_EN to compare the slave readback q_fb with d_out in DONE (sticky err).
module ms_latch_sequencer #(
  parameter int WIDTH = 8,
  parameter int HOLD  = 3,
  parameter int GAP   = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [1:0]       i_req,
  input  logic [WIDTH-1:0] i_data0,
  input  logic [WIDTH-1:0] i_data1,
  input  logic [WIDTH-1:0] i_q_fb,
  output logic [1:0]       o_ack,
  output logic [WIDTH-1:0] o_d_out,
  output logic             o_en_m,
  output logic             o_en_s,
  output logic             o_busy,
  output logic             o_grant_id,
  output logic             o_err
);

  localparam int MAXC = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_MASTER, S_GAP, S_SLAVE, S_DONE
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_last_grant;
  logic             r_grant_id;
  logic [WIDTH-1:0] r_d_out;
  logic             r_en_m;
  logic             r_en_s;
  logic [1:0]       r_ack;
  logic             r_err;
  logic             w_winner;

  // Requester 1 wins when alone, or on a tie when requester 0 won last time.
  assign w_winner = i_req[1] & (~i_req[0] | ~r_last_grant);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_d_out      <= '0;
      r_en_m       <= 1'b0;
      r_en_s       <= 1'b0;
      r_ack        <= 2'b00;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req != 2'b00) begin
            r_grant_id   <= w_winner;
            r_last_grant <= w_winner;
            r_d_out      <= w_winner ? i_data1 : i_data0;
            r_state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_en_m  <= 1'b1;
          r_cnt   <= HOLD_LD;
          r_state <= S_MASTER;
        end
        S_MASTER: begin
          if (r_cnt == '0) begin
            r_en_m  <= 1'b0;
            r_cnt   <= GAP_LD;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt == '0) begin
            r_en_s  <= 1'b1;
            r_cnt   <= HOLD_LD;
            r_state <= S_SLAVE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_SLAVE: begin
          if (r_cnt == '0) begin
            r_en_s  <= 1'b0;
            r_ack   <= r_grant_id ? 2'b10 : 2'b01;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_ack   <= 2'b00;
          r_state <= S_IDLE;
`ifdef MS_SEQ_VERIFY_EN
          if (i_q_fb != r_d_out) r_err <= 1'b1;
`endif
        end
        default: begin
          r_en_m  <= 1'b0;
          r_en_s  <= 1'b0;
          r_ack   <= 2'b00;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifndef MS_SEQ_VERIFY_EN
  logic w_unused_q_fb;
  assign w_unused_q_fb = ^{i_q_fb, r_err};
`endif

  assign o_ack      = r_ack;
  assign o_d_out    = r_d_out;
  assign o_en_m     = r_en_m;
  assign o_en_s     = r_en_s;
  assign o_busy     = (r_state != S_IDLE);
  assign o_grant_id = r_grant_id;
`ifdef MS_SEQ_VERIFY_EN
  assign o_err      = r_err;
`else
  assign o_err      = 1'b0;
`endif

endmodule

// File: tb/tb_ms_latch_sequencer.sv
// tb/tb_ms_latch_sequencer.sv - randomized check of two sequencer instances against a timeline model
module tb_ms_latch_sequencer;

  localparam int W  = 8;
  localparam int HA = 3;
  localparam int GA = 2;
  localparam int HB = 1;
  localparam int GB = 1;
`ifdef MS_SEQ_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic [1:0]   req = 2'b00;
  logic [W-1:0] d0 = '0;
  logic [W-1:0] d1 = '0;
  logic         corrupt = 1'b0;

  logic [W-1:0] q_fb [2];
  logic [1:0]   ack  [2];
  logic [W-1:0] dout [2];
  logic         en_m [2];
  logic         en_s [2];
  logic         busy [2];
  logic         gid  [2];
  logic         err  [2];

  // Latch bank seen by each instance: master follows d_out while en_m, slave follows master while en_s.
  logic [W-1:0] m_lat [2];
  logic [W-1:0] s_lat [2];
  assign q_fb[0] = s_lat[0] ^ W'(corrupt);
  assign q_fb[1] = s_lat[1] ^ W'(corrupt);

  ms_latch_sequencer #(.WIDTH(W), .HOLD(HA), .GAP(GA)) u0 (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_data0(d0), .i_data1(d1), .i_q_fb(q_fb[0]),
    .o_ack(ack[0]), .o_d_out(dout[0]), .o_en_m(en_m[0]), .o_en_s(en_s[0]),
    .o_busy(busy[0]), .o_grant_id(gid[0]), .o_err(err[0])
  );

  ms_latch_sequencer #(.WIDTH(W), .HOLD(HB), .GAP(GB)) u1 (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_data0(d0), .i_data1(d1), .i_q_fb(q_fb[1]),
    .o_ack(ack[1]), .o_d_out(dout[1]), .o_en_m(en_m[1]), .o_en_s(en_s[1]),
    .o_busy(busy[1]), .o_grant_id(gid[1]), .o_err(err[1])
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int hp(input int i);
    return (i == 0) ? HA : HB;
  endfunction

  function automatic int gp(input int i);
    return (i == 0) ? GA : GB;
  endfunction

  // Model: a transaction is just the number of edges k elapsed since its grant edge.
  bit           m_valid = 1'b0;
  bit           m_act   [2] = '{1'b0, 1'b0};
  int           m_k     [2] = '{0, 0};
  bit           m_grant [2] = '{1'b0, 1'b0};
  bit           m_last  [2] = '{1'b1, 1'b1};
  bit           m_err   [2] = '{1'b0, 1'b0};
  logic [W-1:0] m_data  [2] = '{8'h00, 8'h00};
  int           mh, mg;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      mh = hp(i);
      mg = gp(i);
      if (rst) begin
        m_valid    = 1'b1;
        m_act[i]   = 1'b0;
        m_k[i]     = 0;
        m_grant[i] = 1'b0;
        m_last[i]  = 1'b1;
        m_err[i]   = 1'b0;
        m_data[i]  = '0;
      end else if (!m_act[i]) begin
        if (req != 2'b00) begin
          if (req == 2'b01)      m_grant[i] = 1'b0;
          else if (req == 2'b10) m_grant[i] = 1'b1;
          else                   m_grant[i] = !m_last[i];
          m_last[i] = m_grant[i];
          m_data[i] = m_grant[i] ? d1 : d0;
          m_act[i]  = 1'b1;
          m_k[i]    = 0;
        end
      end else begin
        m_k[i]++;
        if (m_k[i] == 2 + 2 * mh + mg) begin
          m_act[i] = 1'b0;
          if (VERIFY && (q_fb[i] != m_data[i])) m_err[i] = 1'b1;
        end
      end
    end
  end

  function automatic logic [1:0] exp_ack(input int i);
    if (m_act[i] && m_k[i] == 1 + 2 * hp(i) + gp(i)) return m_grant[i] ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic tick();
    bit    em, es;
    string p;
    @(negedge clk);
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        em = m_act[i] && m_k[i] >= 1 && m_k[i] <= hp(i);
        es = m_act[i] && m_k[i] >= 1 + hp(i) + gp(i) && m_k[i] <= 2 * hp(i) + gp(i);
        p  = $sformatf("u%0d_", i);
        chk({p, "d_out"},    dout[i],            m_data[i]);
        chk({p, "en_m"},     en_m[i],            em);
        chk({p, "en_s"},     en_s[i],            es);
        chk({p, "ack"},      ack[i],             exp_ack(i));
        chk({p, "busy"},     busy[i],            m_act[i]);
        chk({p, "grant_id"}, gid[i],             m_grant[i]);
        chk({p, "err"},      err[i],             m_err[i]);
        chk({p, "overlap"},  en_m[i] & en_s[i],  1'b0);
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (en_m[i] === 1'b1) m_lat[i] = dout[i];
      if (en_s[i] === 1'b1) s_lat[i] = m_lat[i];
    end
  endtask

  task automatic write_until_ack(input logic [1:0] r, input int budget);
    req = r;
    for (int c = 0; c < budget; c++) begin
      tick();
      if ((exp_ack(0) & r) != 2'b00) req = 2'b00;
    end
    req = 2'b00;
  endtask

  logic [1:0] a;
  bit         want [2];

  initial begin
    m_lat[0] = '0; m_lat[1] = '0;
    s_lat[0] = '0; s_lat[1] = '0;
    want[0] = 1'b0; want[1] = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // reset lands on E2 while u0 is in MASTER
    req = 2'b01; d0 = 8'hA5;
    tick();
    tick();
    rst = 1'b1; req = 2'b00;
    tick();
    rst = 1'b0;
    repeat (3) tick();

    d0 = 8'h3C;
    write_until_ack(2'b01, 13);

    // tie from reset: alternating grants, one write per 11 cycles on u0
    rst = 1'b1;
    tick();
    rst = 1'b0; d0 = 8'h11; d1 = 8'h22; req = 2'b11;
    repeat (46) tick();
    req = 2'b00;
    repeat (12) tick();

    // early drop with data scrambled after the grant
    req = 2'b10; d1 = 8'h7E;
    tick();
    req = 2'b00; d1 = 8'h00;
    repeat (12) tick();

    // readback: clean, corrupted, then clean again before reset clears err
    d0 = 8'h5A; corrupt = 1'b0;
    write_until_ack(2'b01, 13);
    d0 = 8'hC3; corrupt = 1'b1;
    write_until_ack(2'b01, 13);
    d0 = 8'h96; corrupt = 1'b0;
    write_until_ack(2'b01, 13);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    for (int c = 0; c < 2500; c++) begin
      tick();
      a = exp_ack(0);
      for (int r = 0; r < 2; r++) begin
        if (want[r] && a[r]) begin
          want[r] = ($urandom_range(3) == 0);
        end else if (want[r]) begin
          if ($urandom_range(39) == 0) want[r] = 1'b0;
        end else if ($urandom_range(5) == 0) begin
          want[r] = 1'b1;
          if (r == 0) d0 = W'($urandom);
          else        d1 = W'($urandom);
        end
      end
      if ($urandom_range(9) == 0) d0 = W'($urandom);
      if ($urandom_range(9) == 0) d1 = W'($urandom);
      req     = {want[1], want[0]};
      rst     = ($urandom_range(299) == 0);
      corrupt = ($urandom_range(2) == 0);
    end
    rst = 1'b0; req = 2'b00;
    repeat (12) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
